// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MIPS load/store front end: opcode encodings,
// lane geometry and the in-flight load metadata carried alongside the RAM read.
package mem_access_unit_pkg;

    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 8;

    localparam logic [2:0] OP_BYTE  = 3'b000;
    localparam logic [2:0] OP_HALF  = 3'b001;
    localparam logic [2:0] OP_WORD  = 3'b011;
    localparam logic [2:0] OP_BYTEU = 3'b100;
    localparam logic [2:0] OP_HALFU = 3'b101;

    typedef struct packed {
        logic       valid;
        logic [2:0] op;
        logic [1:0] off;
    } load_meta_t;

    function automatic logic op_defined(input logic [2:0] op);
        return (op == OP_BYTE) || (op == OP_HALF) || (op == OP_WORD) ||
               (op == OP_BYTEU) || (op == OP_HALFU);
    endfunction

    // The low two opcode bits encode the access size for every defined op.
    function automatic logic is_half(input logic [2:0] op);
        return op[1:0] == 2'b01;
    endfunction

    function automatic logic is_word(input logic [2:0] op);
        return op[1:0] == 2'b11;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extract.sv
// Combinational load-data extraction: picks the addressed byte/half out of a
// RAM word and sign- or zero-extends it according to the load opcode.
module load_extract
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]                  i_op,
    input  logic [1:0]                  i_off,
    input  logic [NUM_LANES*LANE_W-1:0] i_word,
    output logic [NUM_LANES*LANE_W-1:0] o_data
);

    logic [LANE_W-1:0]   lane_byte;
    logic [2*LANE_W-1:0] lane_half;

    always_comb begin
        lane_byte = i_word[{i_off, 3'b000} +: LANE_W];
        lane_half = i_off[1] ? i_word[4*LANE_W-1:2*LANE_W] : i_word[2*LANE_W-1:0];
        case (i_op)
            OP_BYTE:  o_data = {{(3*LANE_W){lane_byte[LANE_W-1]}}, lane_byte};
            OP_BYTEU: o_data = {{(3*LANE_W){1'b0}}, lane_byte};
            OP_HALF:  o_data = {{(2*LANE_W){lane_half[2*LANE_W-1]}}, lane_half};
            OP_HALFU: o_data = {{(2*LANE_W){1'b0}}, lane_half};
            OP_WORD:  o_data = i_word;
            default:  o_data = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MIPS load/store front end for a byte-enabled data RAM: decodes requests into
// RAM controls, tracks loads through the read latency and registers the result.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter  int NB_DATA     = 32,
    parameter  int NB_ADDR     = 32,
    parameter  int RAM_DEPTH   = 2048,
    parameter  int RAM_LATENCY = 2,
    localparam int RAM_AW      = $clog2(RAM_DEPTH)
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_load,
    input  logic                 i_store,
    input  logic [2:0]           i_op,
    input  logic [NB_ADDR-1:0]   i_addr,
    input  logic [NB_DATA-1:0]   i_wdata,
    output logic [NB_DATA-1:0]   o_load_data,
    output logic                 o_load_valid,
    output logic                 o_exc,
    output logic [RAM_AW-1:0]    o_ram_addr,
    output logic [NB_DATA-1:0]   o_ram_data,
    output logic [NUM_LANES-1:0] o_ram_we,
    output logic                 o_ram_en,
    output logic                 o_ram_rea,
    output logic                 o_ram_rst,
    input  logic [NB_DATA-1:0]   i_ram_data
);

    logic [1:0]           off;
    logic                 req;
    logic                 illegal;
    logic                 misaligned;
    logic                 accept;
    logic [NUM_LANES-1:0] store_we;
    logic [NB_DATA-1:0]   ram_data;
    load_meta_t           meta_in;
    load_meta_t           meta_tail;
    load_meta_t           meta_d [RAM_LATENCY];
    load_meta_t           meta_q [RAM_LATENCY];
    logic [NB_DATA-1:0]   ext_data;
    logic                 exc_d;
    logic                 exc_q;
    logic                 load_valid_d;
    logic                 load_valid_q;
    logic [NB_DATA-1:0]   load_data_d;
    logic [NB_DATA-1:0]   load_data_q;
    logic                 unused_addr_hi;

    // Faulting requests never reach the RAM; the exception strobe follows a cycle later.
    always_comb begin
        off        = i_addr[1:0];
        req        = i_load | i_store;
        illegal    = (i_load & i_store) | (req & ~op_defined(i_op));
        misaligned = req & ((is_half(i_op) & off[0]) | (is_word(i_op) & (off != 2'b00)));
        accept     = i_reset & req & ~illegal & ~misaligned;
        exc_d      = i_reset & (illegal | misaligned);

        if (is_word(i_op)) begin
            ram_data = i_wdata;
            store_we = 4'b1111;
        end else if (is_half(i_op)) begin
            ram_data = {2{i_wdata[2*LANE_W-1:0]}};
            store_we = off[1] ? 4'b1100 : 4'b0011;
        end else begin
            ram_data = {NUM_LANES{i_wdata[LANE_W-1:0]}};
            store_we = 4'b0001 << off;
        end

        meta_in.valid = accept & i_load;
        meta_in.op    = i_op;
        meta_in.off   = off;
    end

    assign o_ram_addr     = i_addr[RAM_AW+1:2];
    assign o_ram_data     = ram_data;
    assign o_ram_we       = (accept & i_store) ? store_we : '0;
    assign o_ram_en       = accept;
    assign o_ram_rea      = 1'b1;
    assign o_ram_rst      = ~i_reset;
    assign unused_addr_hi = ^{i_addr[NB_ADDR-1:RAM_AW+2]};

    // Load metadata walks alongside the RAM read so it reaches the tail with the data.
    always_comb begin
        meta_d[0] = meta_in;
        for (int i = 1; i < RAM_LATENCY; i++) begin
            meta_d[i] = meta_q[i-1];
        end
    end

    assign meta_tail = meta_q[RAM_LATENCY-1];

    load_extract u_load_extract (
        .i_op   (meta_tail.op),
        .i_off  (meta_tail.off),
        .i_word (i_ram_data),
        .o_data (ext_data)
    );

    always_comb begin
        load_valid_d = meta_tail.valid;
        load_data_d  = meta_tail.valid ? ext_data : load_data_q;
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            for (int i = 0; i < RAM_LATENCY; i++) begin
                meta_q[i] <= '0;
            end
            exc_q        <= 1'b0;
            load_valid_q <= 1'b0;
            load_data_q  <= '0;
        end else begin
            meta_q       <= meta_d;
            exc_q        <= exc_d;
            load_valid_q <= load_valid_d;
            load_data_q  <= load_data_d;
        end
    end

    assign o_exc        = exc_q;
    assign o_load_valid = load_valid_q;
    assign o_load_data  = load_data_q;

endmodule
